// File: rtl/find_first_arb_pkg.sv
// Shared constants and sizing helper for the find-first arbiter and its tree.
package find_first_arb_pkg;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  // Index width never drops below one bit, so N=1 still has a usable index port.
  function automatic int calc_logn(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/find_first_arb_tree.sv
// Combinational find-first tree: pairwise reduction of lanes, carrying data and index per node.
module find_first_tree
  import find_first_arb_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int DATAW   = 8,
  parameter  int REVERSE = 0,
  localparam int LOGN    = calc_logn(N)
) (
  input  logic [N-1:0]       valid_i,
  input  logic [N*DATAW-1:0] data_i,
  output logic               valid_o,
  output logic [DATAW-1:0]   data_o,
  output logic [LOGN-1:0]    index_o
);

  localparam int P = 1 << LOGN;

  genvar l, j;
  for (l = 0; l <= LOGN; l++) begin : g_lvl
    localparam int W = P >> l;
    logic [W-1:0]       v;
    logic [DATAW-1:0]   d  [W];
    logic [LOGN-1:0]    ix [W];

    for (j = 0; j < W; j++) begin : g_node
      if (l == 0) begin : g_leaf
        // Padding leaves past N are permanently invalid, so they can never win.
        if (j < N) begin : g_real
          assign v[j] = valid_i[j];
          assign d[j] = data_i[j*DATAW +: DATAW];
        end else begin : g_pad
          assign v[j] = 1'b0;
          assign d[j] = '0;
        end
        assign ix[j] = LOGN'(j);
      end else begin : g_join
        logic take_lo;
        if (REVERSE == 0) begin : g_lo_first
          assign take_lo = g_lvl[l-1].v[2*j];
        end else begin : g_hi_first
          assign take_lo = ~g_lvl[l-1].v[2*j+1];
        end
        assign v[j]  = g_lvl[l-1].v[2*j] | g_lvl[l-1].v[2*j+1];
        assign d[j]  = take_lo ? g_lvl[l-1].d[2*j]  : g_lvl[l-1].d[2*j+1];
        assign ix[j] = take_lo ? g_lvl[l-1].ix[2*j] : g_lvl[l-1].ix[2*j+1];
      end
    end
  end

  assign valid_o = g_lvl[LOGN].v[0];
  assign data_o  = g_lvl[LOGN].d[0];
  assign index_o = g_lvl[LOGN].ix[0];

endmodule

// File: rtl/find_first_arb.sv
// Registered find-first arbiter: fixed or round-robin lane select, one elastic output slot.
module find_first_arb
  import find_first_arb_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int DATAW   = 8,
  parameter  int REVERSE = 0,
  parameter  int RR      = PRIO_FIXED,
  localparam int LOGN    = calc_logn(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N-1:0]       valid_in,
  input  logic [N*DATAW-1:0] data_in,
  output logic [N-1:0]       grant_out,
  output logic               valid_out,
  output logic [DATAW-1:0]   data_out,
  output logic [LOGN-1:0]    index_out,
  input  logic               ready_out
);

  logic             any;
  logic [LOGN-1:0]  sel_idx;
  logic [DATAW-1:0] sel_data;
  logic             can_load;
  logic             fire;

  logic             valid_q, valid_d;
  logic [DATAW-1:0] data_q,  data_d;
  logic [LOGN-1:0]  index_q, index_d;

  if (RR == PRIO_RR) begin : g_rr
    logic [LOGN-1:0]  ptr_q, ptr_d;
    logic [N-1:0]     mask;
    logic [N-1:0]     masked;
    logic             m_v, u_v;
    logic [DATAW-1:0] m_d, u_d;
    logic [LOGN-1:0]  m_i, u_i;

    always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) mask[i] = (i >= int'(ptr_q));
    end
    assign masked = valid_in & mask;

    // Masked search covers ptr..N-1; the unmasked one supplies the wrap-around winner.
    find_first_tree #(.N(N), .DATAW(DATAW), .REVERSE(0)) u_masked (
      .valid_i(masked), .data_i(data_in), .valid_o(m_v), .data_o(m_d), .index_o(m_i)
    );
    find_first_tree #(.N(N), .DATAW(DATAW), .REVERSE(0)) u_full (
      .valid_i(valid_in), .data_i(data_in), .valid_o(u_v), .data_o(u_d), .index_o(u_i)
    );

    assign any      = u_v;
    assign sel_idx  = m_v ? m_i : u_i;
    assign sel_data = m_v ? m_d : u_d;

    always_comb begin
      ptr_d = ptr_q;
      if (fire) ptr_d = (sel_idx == LOGN'(N-1)) ? '0 : sel_idx + LOGN'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ptr_q <= '0;
      else          ptr_q <= ptr_d;
    end
  end else begin : g_fixed
    find_first_tree #(.N(N), .DATAW(DATAW), .REVERSE(REVERSE)) u_tree (
      .valid_i(valid_in), .data_i(data_in), .valid_o(any), .data_o(sel_data), .index_o(sel_idx)
    );
  end

  // Gating with reset_n keeps grants silent while the slot is held in reset.
  assign can_load = ~valid_q | ready_out;
  assign fire     = any & can_load & reset_n;

  always_comb begin
    grant_out = '0;
    for (int i = 0; i < N; i++) grant_out[i] = fire && (sel_idx == LOGN'(i));
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    if (fire) begin
      valid_d = 1'b1;
      data_d  = sel_data;
      index_d = sel_idx;
    end else if (ready_out) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign index_out = index_q;

endmodule

// File: tb/tb_find_first_arb.sv
// Bench for find_first_arb: four configurations share one stimulus stream and a behavioural model.
module tb_find_first_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  vin;
  logic [31:0] din;
  logic        rdy;

  logic [3:0] g_fix, g_rev, g_rr4;
  logic [2:0] g_rr3;
  logic       v_fix, v_rev, v_rr4, v_rr3;
  logic [7:0] d_fix, d_rev, d_rr4, d_rr3;
  logic [1:0] i_fix, i_rev, i_rr4, i_rr3;

  find_first_arb #(.N(4), .DATAW(8), .REVERSE(0), .RR(0)) u_fix (
    .clk(clk), .reset_n(rst_n), .valid_in(vin), .data_in(din), .grant_out(g_fix),
    .valid_out(v_fix), .data_out(d_fix), .index_out(i_fix), .ready_out(rdy));
  find_first_arb #(.N(4), .DATAW(8), .REVERSE(1), .RR(0)) u_rev (
    .clk(clk), .reset_n(rst_n), .valid_in(vin), .data_in(din), .grant_out(g_rev),
    .valid_out(v_rev), .data_out(d_rev), .index_out(i_rev), .ready_out(rdy));
  find_first_arb #(.N(4), .DATAW(8), .REVERSE(0), .RR(1)) u_rr4 (
    .clk(clk), .reset_n(rst_n), .valid_in(vin), .data_in(din), .grant_out(g_rr4),
    .valid_out(v_rr4), .data_out(d_rr4), .index_out(i_rr4), .ready_out(rdy));
  find_first_arb #(.N(3), .DATAW(8), .REVERSE(0), .RR(1)) u_rr3 (
    .clk(clk), .reset_n(rst_n), .valid_in(vin[2:0]), .data_in(din[23:0]), .grant_out(g_rr3),
    .valid_out(v_rr3), .data_out(d_rr3), .index_out(i_rr3), .ready_out(rdy));

  int cfg_n   [4] = '{4, 4, 4, 3};
  bit cfg_rev [4] = '{0, 1, 0, 0};
  bit cfg_rr  [4] = '{0, 0, 1, 1};

  logic       mv   [4];
  logic [7:0] md   [4];
  logic [1:0] mi   [4];
  int         mptr [4];

  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [3:0] obs_grant(int k);
    case (k)
      0: return g_fix;
      1: return g_rev;
      2: return g_rr4;
      default: return {1'b0, g_rr3};
    endcase
  endfunction

  function automatic logic obs_valid(int k);
    case (k)
      0: return v_fix;
      1: return v_rev;
      2: return v_rr4;
      default: return v_rr3;
    endcase
  endfunction

  function automatic logic [7:0] obs_data(int k);
    case (k)
      0: return d_fix;
      1: return d_rev;
      2: return d_rr4;
      default: return d_rr3;
    endcase
  endfunction

  function automatic logic [1:0] obs_index(int k);
    case (k)
      0: return i_fix;
      1: return i_rev;
      2: return i_rr4;
      default: return i_rr3;
    endcase
  endfunction

  // Winner by the priority rules: round-robin walks lanes starting at the pointer, wrapping.
  function automatic int pick(int k, logic [3:0] v);
    int n = cfg_n[k];
    if (cfg_rr[k]) begin
      for (int s = 0; s < n; s++) if (v[(mptr[k] + s) % n]) return (mptr[k] + s) % n;
    end else if (cfg_rev[k]) begin
      for (int s = n - 1; s >= 0; s--) if (v[s]) return s;
    end else begin
      for (int s = 0; s < n; s++) if (v[s]) return s;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_grant(int k);
    int w = pick(k, vin);
    if (w >= 0 && (!mv[k] || rdy) && rst_n) return 4'b0001 << w;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mv[k] = 1'b0; md[k] = '0; mi[k] = '0; mptr[k] = 0;
    end
  endtask

  task automatic advance();
    int          w [4];
    logic        f [4];
    logic [31:0] dsnap = din;
    for (int k = 0; k < 4; k++) begin
      w[k] = pick(k, vin);
      f[k] = (w[k] >= 0) && (!mv[k] || rdy) && rst_n;
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (f[k]) begin
        mv[k] = 1'b1;
        md[k] = dsnap[w[k]*8 +: 8];
        mi[k] = 2'(w[k]);
        if (cfg_rr[k]) mptr[k] = (w[k] + 1) % cfg_n[k];
      end else if (rdy && rst_n) begin
        mv[k] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; vin = '0; din = '0; rdy = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vin = 4'b1111; din = $urandom; rdy = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs_valid(k) !== 1'b0 || obs_data(k) !== 8'h00 || obs_index(k) !== 2'd0 ||
          obs_grant(k) !== 4'b0000) begin
        n_err++;
        $display("FAIL reset[%0d]: got v=%b d=%h i=%0d g=%b, want v=0 d=00 i=0 g=0000",
                 k, obs_valid(k), obs_data(k), obs_index(k), obs_grant(k));
      end
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    vin = 4'b1010; din = {8'h33, 8'h22, 8'h11, 8'h00}; rdy = 1'b1;
    #1;
    n_checks++;
    if (g_fix !== 4'b0010) begin
      n_err++; $display("FAIL fixed_grant: got %b want 0010", g_fix);
    end
    n_checks++;
    if (g_rev !== 4'b1000) begin
      n_err++; $display("FAIL reverse_grant: got %b want 1000", g_rev);
    end
    advance();
    n_checks++;
    if (v_fix !== 1'b1 || d_fix !== 8'h11 || i_fix !== 2'd1) begin
      n_err++; $display("FAIL fixed_out: got v=%b d=%h i=%0d want v=1 d=11 i=1", v_fix, d_fix, i_fix);
    end
    n_checks++;
    if (v_rev !== 1'b1 || d_rev !== 8'h33 || i_rev !== 2'd3) begin
      n_err++; $display("FAIL reverse_out: got v=%b d=%h i=%0d want v=1 d=33 i=3", v_rev, d_rev, i_rev);
    end
  endtask

  task automatic test_rr_rotate();
    int seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    vin = 4'b1111; din = $urandom; rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (g_rr4 !== (4'b0001 << seq[c])) begin
        n_err++; $display("FAIL rr4_grant[%0d]: got %b want lane %0d", c, g_rr4, seq[c]);
      end
      advance();
      n_checks++;
      if (v_rr4 !== 1'b1 || i_rr4 !== 2'(seq[c]) || d_rr4 !== din[seq[c]*8 +: 8]) begin
        n_err++; $display("FAIL rr4_out[%0d]: got v=%b i=%0d d=%h want i=%0d", c, v_rr4, i_rr4, d_rr4, seq[c]);
      end
      n_checks++;
      if (i_rr3 !== mi[3]) begin
        n_err++; $display("FAIL rr3_rotate[%0d]: got i=%0d want %0d", c, i_rr3, mi[3]);
      end
    end
  endtask

  task automatic test_rr_n3_sparse();
    int seq [4] = '{0, 2, 0, 2};
    do_reset();
    vin = 4'b0101; din = $urandom; rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (g_rr3 !== (3'b001 << seq[c])) begin
        n_err++; $display("FAIL rr3_grant[%0d]: got %b want lane %0d", c, g_rr3, seq[c]);
      end
      advance();
      n_checks++;
      if (v_rr3 !== 1'b1 || i_rr3 !== 2'(seq[c])) begin
        n_err++; $display("FAIL rr3_out[%0d]: got v=%b i=%0d want i=%0d", c, v_rr3, i_rr3, seq[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] hold;
    do_reset();
    vin = 4'b0100; din = $urandom; rdy = 1'b1;
    hold = din[23:16];
    #1;
    advance();
    vin = 4'b0001; rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (g_rr4 !== 4'b0000 || g_fix !== 4'b0000) begin
        n_err++; $display("FAIL bp_grant[%0d]: got rr=%b fix=%b want 0000", c, g_rr4, g_fix);
      end
      advance();
      n_checks++;
      if (v_rr4 !== 1'b1 || i_rr4 !== 2'd2 || d_rr4 !== hold) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v=%b i=%0d d=%h want v=1 i=2 d=%h", c, v_rr4, i_rr4, d_rr4, hold);
      end
    end
    rdy = 1'b1;
    #1;
    n_checks++;
    if (g_rr4 !== 4'b0001) begin
      n_err++; $display("FAIL bp_release_grant: got %b want 0001", g_rr4);
    end
    advance();
    n_checks++;
    if (v_rr4 !== 1'b1 || i_rr4 !== 2'd0 || d_rr4 !== din[7:0]) begin
      n_err++; $display("FAIL bp_reload: got v=%b i=%0d d=%h want v=1 i=0 d=%h", v_rr4, i_rr4, d_rr4, din[7:0]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    vin = 4'b1111; din = $urandom; rdy = 1'b1;
    #1;
    advance();
    advance();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs_valid(k) !== 1'b0 || obs_index(k) !== 2'd0 || obs_grant(k) !== 4'b0000) begin
        n_err++;
        $display("FAIL async_reset[%0d]: got v=%b i=%0d g=%b want all 0", k, obs_valid(k), obs_index(k), obs_grant(k));
      end
    end
    #2 rst_n = 1'b1;
    vin = 4'b0110;
    #1;
    n_checks++;
    if (g_rr4 !== 4'b0010) begin
      n_err++; $display("FAIL post_reset_grant: got %b want 0010", g_rr4);
    end
    advance();
    n_checks++;
    if (v_rr4 !== 1'b1 || i_rr4 !== 2'd1) begin
      n_err++; $display("FAIL post_reset_out: got v=%b i=%0d want v=1 i=1", v_rr4, i_rr4);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      vin = 4'($urandom);
      din = $urandom;
      rdy = ($urandom_range(3) != 0);
      #1;
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (obs_grant(k) !== exp_grant(k)) begin
          n_err++; $display("FAIL rand_grant[%0d] cyc %0d: got %b want %b", k, c, obs_grant(k), exp_grant(k));
        end
      end
      advance();
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (obs_valid(k) !== mv[k] || obs_data(k) !== md[k] || obs_index(k) !== mi[k]) begin
          n_err++;
          $display("FAIL rand_out[%0d] cyc %0d: got v=%b d=%h i=%0d want v=%b d=%h i=%0d",
                   k, c, obs_valid(k), obs_data(k), obs_index(k), mv[k], md[k], mi[k]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; vin = '0; din = '0; rdy = 1'b0;
    model_reset();
    test_reset();
    test_fixed_priority();
    test_rr_rotate();
    test_rr_n3_sparse();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
